csr_out_packer: RTL and testbench

CSR_OUT_PACKER -- requirements
Module: csr_out_packer

---
 rtl/matraptor_pkg.sv | 22 ++
 rtl/csr_out_packer_if.sv | 45 ++++
 rtl/csr_out_packer_fifo.sv | 56 +++++
 rtl/csr_out_packer.sv | 99 +++++++++
 tb/tb_csr_out_packer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/matraptor_pkg.sv
// Shared definitions for the MatRaptor CSR output path: default widths,
// the packed CSR element layout and the output-packer state encoding.
package matraptor_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IDX_W_DEF  = 16;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  row;
    logic [IDX_W_DEF-1:0]  col;
    logic [DATA_W_DEF-1:0] val;
  } csr_elem_t;

  typedef enum logic [2:0] {
    PK_PTR0  = 3'd0,
    PK_RUN   = 3'd1,
    PK_PTR   = 3'd2,
    PK_DRAIN = 3'd3,
    PK_DONE  = 3'd4
  } packer_state_e;

endpackage

// File: rtl/csr_out_packer_if.sv
// Stream bundle around the CSR packer: element input (s), CSR element output (e)
// and row-pointer output (p). The packer takes the slave view.
interface csr_out_packer_if
  import matraptor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int NNZ_W  = 32
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_val;
  logic [IDX_W-1:0]  s_col;
  logic              s_last;

  logic              e_valid;
  logic              e_ready;
  logic [IDX_W-1:0]  e_row;
  logic [IDX_W-1:0]  e_col;
  logic [DATA_W-1:0] e_val;

  logic              p_valid;
  logic              p_ready;
  logic [NNZ_W-1:0]  p_ptr;

  modport master (
    output s_valid, s_val, s_col, s_last,
    input  s_ready,
    input  e_valid, e_row, e_col, e_val,
    output e_ready,
    input  p_valid, p_ptr,
    output p_ready
  );

  modport slave (
    input  s_valid, s_val, s_col, s_last,
    output s_ready,
    output e_valid, e_row, e_col, e_val,
    input  e_ready,
    output p_valid, p_ptr,
    input  p_ready
  );

endinterface

// File: rtl/csr_out_packer_fifo.sv
// First-word-fall-through FIFO: a word pushed on one edge is visible on dout_o
// right after that edge. dout_o reads zero while empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/csr_out_packer.sv
// Packs the merged PE element stream into CSR form: buffered (row,col,val)
// elements plus a row-pointer stream, with an end-of-matrix drain and done pulse.
module csr_out_packer
  import matraptor_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int NNZ_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_ZERO  = 0
) (
  input  logic             clk,
  input  logic             rst,
  csr_out_packer_if.slave  bus,
  input  logic             fin_i,
  output logic             done_o
);

  localparam logic [2:0] S_PTR0  = PK_PTR0;
  localparam logic [2:0] S_RUN   = PK_RUN;
  localparam logic [2:0] S_PTR   = PK_PTR;
  localparam logic [2:0] S_DRAIN = PK_DRAIN;
  localparam logic [2:0] S_DONE  = PK_DONE;
  localparam int         ELEM_W  = 2 * IDX_W + DATA_W;

  logic [2:0]        state_q, state_d;
  logic [NNZ_W-1:0]  nnz_q, nnz_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic              fin_q, fin_d;
  logic              fifo_full, fifo_empty;
  logic              s_fire, p_fire, drop, push;
  logic [ELEM_W-1:0] fifo_dout;

  // A pending fin blocks further input so the drain sees a stable FIFO.
  assign bus.s_ready = (state_q == S_RUN) && !fin_q && !fifo_full;
  assign s_fire      = bus.s_valid && bus.s_ready;
  assign drop        = (DROP_ZERO != 0) && (bus.s_val == '0);
  assign push        = s_fire && !drop;

  assign bus.p_valid = !rst && ((state_q == S_PTR0) || (state_q == S_PTR));
  assign bus.p_ptr   = (state_q == S_PTR) ? nnz_q : '0;
  assign p_fire      = bus.p_valid && bus.p_ready;
  assign done_o      = (state_q == S_DRAIN) && fifo_empty;

  sync_fifo #(
    .WIDTH (ELEM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({row_q, bus.s_col, bus.s_val}),
    .pop_i   (bus.e_ready),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.e_valid = !fifo_empty;
  assign {bus.e_row, bus.e_col, bus.e_val} = fifo_dout;

  always_comb begin
    state_d = state_q;
    nnz_d   = nnz_q;
    row_d   = row_q;
    fin_d   = fin_q || (fin_i && (state_q != S_DONE));
    if (push) nnz_d = nnz_q + NNZ_W'(1);
    case (state_q)
      S_PTR0:  if (p_fire) state_d = S_RUN;
      S_RUN: begin
        if (fin_q)                        state_d = S_DRAIN;
        else if (s_fire && bus.s_last)    state_d = S_PTR;
      end
      S_PTR: begin
        if (p_fire) begin
          row_d   = row_q + IDX_W'(1);
          state_d = S_RUN;
        end
      end
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_PTR0;
      nnz_q   <= '0;
      row_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nnz_q   <= nnz_d;
      row_q   <= row_d;
      fin_q   <= fin_d;
    end
  end

endmodule

// File: tb/tb_csr_out_packer.sv
// Directed bench for csr_out_packer (DROP_ZERO=1): row packing, zero drop,
// back-pressure, fin/drain/done and mid-row reset.
module tb_csr_out_packer;
  import matraptor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fin = 1'b0;
  logic done;
  int   checks = 0;
  int   errors = 0;

  csr_out_packer_if bus ();

  csr_out_packer #(.DROP_ZERO(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .fin_i  (fin),
    .done_o (done)
  );

  always #5 clk = ~clk;

  csr_elem_t   e_seen[$];
  logic [31:0] p_seen[$];
  int cyc = 0, last_pop_cyc = -1, done_cyc = -1, done_cnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.e_valid && bus.e_ready) begin
      e_seen.push_back('{row: bus.e_row, col: bus.e_col, val: bus.e_val});
      last_pop_cyc = cyc;
      $display("t=%0t e beat row=%0d col=%0d val=%h", $time, bus.e_row, bus.e_col, bus.e_val);
    end
    if (bus.p_valid && bus.p_ready) begin
      p_seen.push_back(bus.p_ptr);
      $display("t=%0t p beat ptr=%0d", $time, bus.p_ptr);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      $display("t=%0t done pulse", $time);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] col, input logic [31:0] val, input logic last);
    int n;
    n = 0;
    bus.s_valid = 1'b1; bus.s_col = col; bus.s_val = val; bus.s_last = last;
    #1;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_ready", 64'(bus.s_ready), 64'd1);
    if (bus.s_ready) @(posedge clk);
    #1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc, esz, psz;
    logic fire;
    bus.s_valid = 1'b0; bus.s_val = '0; bus.s_col = '0; bus.s_last = 1'b0;
    bus.e_ready = 1'b0; bus.p_ready = 1'b0;
    #2;
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_e_valid", 64'(bus.e_valid), 64'd0);
    chk("rst_p_valid", 64'(bus.p_valid), 64'd0);
    chk("rst_done",    64'(done),        64'd0);
    chk("rst_p_ptr",   64'(bus.p_ptr),   64'd0);
    chk("rst_e_val",   64'(bus.e_val),   64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0; #1;
    chk("ptr0_valid", 64'(bus.p_valid), 64'd1);
    chk("ptr0_ptr",   64'(bus.p_ptr),   64'd0);

    // Basic row of two elements
    bus.p_ready = 1'b1; bus.e_ready = 1'b1;
    tick();
    send(16'd1, 32'h3F800000, 1'b0);
    send(16'd3, 32'h40000000, 1'b1);
    #1;
    chk("row0_p_valid", 64'(bus.p_valid), 64'd1);
    chk("row0_p_ptr",   64'(bus.p_ptr),   64'd2);
    tick(); tick();
    chk("row0_e_count", 64'(e_seen.size()), 64'd2);
    chk("row0_e0", 64'(e_seen[0]), {16'd0, 16'd1, 32'h3F800000});
    chk("row0_e1", 64'(e_seen[1]), {16'd0, 16'd3, 32'h40000000});
    chk("row0_p_seen0", 64'(p_seen[0]), 64'd0);
    chk("row0_p_seen1", 64'(p_seen[1]), 64'd2);

    // Zero-valued closing beat is dropped but still closes the row
    send(16'd5, 32'h00000000, 1'b1);
    #1;
    chk("zero_p_ptr",   64'(bus.p_ptr),   64'd2);
    chk("zero_e_valid", 64'(bus.e_valid), 64'd0);
    tick();
    send(16'd7, 32'h11111111, 1'b1);
    tick(); tick();
    chk("zero_e_count", 64'(e_seen.size()), 64'd3);
    chk("row2_elem",    64'(e_seen[2]), {16'd2, 16'd7, 32'h11111111});
    chk("zero_p_seen",  64'(p_seen[2]), 64'd2);
    chk("row2_p_seen",  64'(p_seen[3]), 64'd3);

    // Back-pressure: 6 offered, 4 fit, then release
    bus.e_ready = 1'b0;
    acc = 0;
    bus.s_valid = 1'b1; bus.s_col = 16'd20; bus.s_val = 32'hA0; bus.s_last = 1'b0;
    for (int i = 0; i < 8 && acc < 6; i++) begin
      #1; fire = bus.s_ready; @(posedge clk); #1;
      if (fire) begin
        acc++;
        bus.s_col = 16'(20 + acc); bus.s_val = 32'hA0 + 32'(acc); bus.s_last = (acc == 5);
        if (acc == 6) bus.s_valid = 1'b0;
      end
    end
    #1;
    chk("bp_accepted", 64'(acc),          64'd4);
    chk("bp_s_ready",  64'(bus.s_ready),  64'd0);
    chk("bp_head_col", 64'(bus.e_col),    64'd20);
    bus.e_ready = 1'b1;
    for (int i = 0; i < 20 && acc < 6; i++) begin
      #1; fire = bus.s_ready; @(posedge clk); #1;
      if (fire) begin
        acc++;
        bus.s_col = 16'(20 + acc); bus.s_val = 32'hA0 + 32'(acc); bus.s_last = (acc == 5);
        if (acc == 6) bus.s_valid = 1'b0;
      end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    repeat (8) tick();
    chk("bp_total", 64'(acc), 64'd6);
    chk("bp_e_count", 64'(e_seen.size()), 64'd9);
    for (int i = 0; i < 6; i++)
      chk($sformatf("bp_elem%0d", i), 64'(e_seen[3+i]), {16'd3, 16'(20 + i), 32'hA0 + 32'(i)});
    chk("bp_p_ptr", 64'(p_seen[4]), 64'd9);

    // fin with three buffered elements and toggling e_ready
    bus.e_ready = 1'b0;
    send(16'd30, 32'hB0, 1'b0);
    send(16'd31, 32'hB1, 1'b0);
    send(16'd32, 32'hB2, 1'b0);
    fin = 1'b1; tick(); fin = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.e_ready = ~bus.e_ready;
      tick();
    end
    chk("fin_done_cnt", 64'(done_cnt), 64'd1);
    chk("fin_done_cyc", 64'(done_cyc), 64'(last_pop_cyc + 1));
    chk("fin_e_count",  64'(e_seen.size()), 64'd12);
    for (int i = 0; i < 3; i++)
      chk($sformatf("fin_elem%0d", i), 64'(e_seen[9+i]), {16'd4, 16'(30 + i), 32'hB0 + 32'(i)});
    bus.s_valid = 1'b1; fin = 1'b1; #1;
    chk("done_s_ready", 64'(bus.s_ready), 64'd0);
    chk("done_p_valid", 64'(bus.p_valid), 64'd0);
    tick(); fin = 1'b0; bus.s_valid = 1'b0;
    tick(); tick();
    chk("done_terminal", 64'(done_cnt), 64'd1);

    // Reset mid-row with two buffered elements and a stalled pointer
    rst = 1'b1; tick(); rst = 1'b0; #1;
    bus.p_ready = 1'b1; bus.e_ready = 1'b0;
    tick();
    bus.p_ready = 1'b0;
    send(16'd40, 32'hC0, 1'b0);
    send(16'd41, 32'hC1, 1'b0);
    #1;
    chk("pre_rst_e_valid", 64'(bus.e_valid), 64'd1);
    rst = 1'b1; #1;
    chk("mid_rst_e_valid", 64'(bus.e_valid), 64'd0);
    chk("mid_rst_p_valid", 64'(bus.p_valid), 64'd0);
    chk("mid_rst_e_val",   64'(bus.e_val),   64'd0);
    tick(); tick();
    rst = 1'b0; #1;
    chk("post_rst_p_valid", 64'(bus.p_valid), 64'd1);
    chk("post_rst_p_ptr",   64'(bus.p_ptr),   64'd0);
    chk("post_rst_e_valid", 64'(bus.e_valid), 64'd0);
    esz = e_seen.size(); psz = p_seen.size();
    bus.e_ready = 1'b1; bus.p_ready = 1'b1;
    tick();
    send(16'd9, 32'hDEADBEEF, 1'b1);
    tick(); tick();
    chk("post_rst_e_count", 64'(e_seen.size()), 64'(esz + 1));
    chk("post_rst_elem",    64'(e_seen[esz]), {16'd0, 16'd9, 32'hDEADBEEF});
    chk("post_rst_ptr0",    64'(p_seen[psz]),   64'd0);
    chk("post_rst_ptr1",    64'(p_seen[psz+1]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
